// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and sizes for the register-file write-back path.
package regfile_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned AW       = 5;
  localparam int unsigned NUM_REGS = 2 ** AW;
  localparam int unsigned REG_ZERO = 0;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } wb_req_e;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// Two-way write-back grant logic with last-grant pointer.
// Policy: round-robin with RF_WB_ARB_RR_EN, else fixed LSU-over-ALU priority.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    i_req_alu,
  input  logic    i_req_lsu,
  output logic    o_gnt_alu,
  output logic    o_gnt_lsu,
  output wb_req_e o_last
);

  wb_req_e r_last;
  logic    w_alu_wins;

  always_comb begin
`ifdef RF_WB_ARB_RR_EN
    w_alu_wins = (r_last == REQ_LSU);
`else
    w_alu_wins = 1'b0;
`endif
    o_gnt_alu = i_req_alu & (~i_req_lsu | w_alu_wins);
    o_gnt_lsu = i_req_lsu & ~o_gnt_alu;
  end

  // A grant always completes a transfer, so the pointer moves on any grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= REQ_LSU;
    end else if (o_gnt_alu || o_gnt_lsu) begin
      r_last <= o_gnt_lsu ? REQ_LSU : REQ_ALU;
    end
  end

  assign o_last = r_last;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register-file write port plus pending-write scoreboard.
// Arbitration policy selected by macro RF_WB_ARB_RR_EN (see rr_arbiter2).
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN = regfile_pkg::XLEN,
  parameter int unsigned AW   = regfile_pkg::AW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alu_wb_valid,
  output logic                 alu_wb_ready,
  input  logic [AW-1:0]        alu_wb_addr,
  input  logic [XLEN-1:0]      alu_wb_data,
  input  logic                 lsu_wb_valid,
  output logic                 lsu_wb_ready,
  input  logic [AW-1:0]        lsu_wb_addr,
  input  logic [XLEN-1:0]      lsu_wb_data,
  input  logic                 issue_valid,
  input  logic [AW-1:0]        issue_rd,
  output logic [(2**AW)-1:0]   busy,
  output logic                 write_en,
  output logic [AW-1:0]        write_address_0,
  output logic [XLEN-1:0]      write_data,
  output logic                 last_grant
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

  logic                w_gnt_alu;
  logic                w_gnt_lsu;
  wb_req_e             w_last;
  logic                w_xfer;
  logic [AW-1:0]       w_addr;
  logic [XLEN-1:0]     w_data;
  logic [(2**AW)-1:0]  w_busy_nxt;

  logic                r_write_en;
  logic [AW-1:0]       r_waddr;
  logic [XLEN-1:0]     r_wdata;
  logic [(2**AW)-1:0]  r_busy;

  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req_alu (alu_wb_valid),
    .i_req_lsu (lsu_wb_valid),
    .o_gnt_alu (w_gnt_alu),
    .o_gnt_lsu (w_gnt_lsu),
    .o_last    (w_last)
  );

  always_comb begin
    w_xfer = w_gnt_alu | w_gnt_lsu;
    w_addr = w_gnt_lsu ? lsu_wb_addr : alu_wb_addr;
    w_data = w_gnt_lsu ? lsu_wb_data : alu_wb_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write_en <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
    end else begin
      r_write_en <= w_xfer && (w_addr != ZERO_ADDR);
      if (w_xfer) begin
        r_waddr <= w_addr;
        r_wdata <= w_data;
      end
    end
  end

  // Clear before set so a same-cycle issue to the written register keeps it busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_write_en) begin
      w_busy_nxt[r_waddr] = 1'b0;
    end
    if (issue_valid && (issue_rd != ZERO_ADDR)) begin
      w_busy_nxt[issue_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign alu_wb_ready    = w_gnt_alu;
  assign lsu_wb_ready    = w_gnt_lsu;
  assign write_en        = r_write_en;
  assign write_address_0 = r_waddr;
  assign write_data      = r_wdata;
  assign busy            = r_busy;
  assign last_grant      = w_last;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter; expected writes are queued with the
// cycle they must appear in and a monitor checks every write_en=1 cycle.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_wb_valid = 1'b0, lsu_wb_valid = 1'b0, issue_valid = 1'b0;
  logic        alu_wb_ready, lsu_wb_ready;
  logic [4:0]  alu_wb_addr = '0, lsu_wb_addr = '0, issue_rd = '0;
  logic [31:0] alu_wb_data = '0, lsu_wb_data = '0;
  logic [31:0] busy;
  logic        write_en;
  logic [4:0]  write_address_0;
  logic [31:0] write_data;
  logic        last_grant;

  int n_checks = 0;
  int n_errors = 0;
  int cnt = 0;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    int          c;
  } exp_t;
  exp_t q[$];

  regfile_wb_arbiter #(.XLEN(32), .AW(5)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .alu_wb_valid    (alu_wb_valid),
    .alu_wb_ready    (alu_wb_ready),
    .alu_wb_addr     (alu_wb_addr),
    .alu_wb_data     (alu_wb_data),
    .lsu_wb_valid    (lsu_wb_valid),
    .lsu_wb_ready    (lsu_wb_ready),
    .lsu_wb_addr     (lsu_wb_addr),
    .lsu_wb_data     (lsu_wb_data),
    .issue_valid     (issue_valid),
    .issue_rd        (issue_rd),
    .busy            (busy),
    .write_en        (write_en),
    .write_address_0 (write_address_0),
    .write_data      (write_data),
    .last_grant      (last_grant)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cnt);
    end
  endtask

  // Monitor: every visible write must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rst_n && write_en) begin
      if (q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: got addr %0d data %h expected no write (cycle %0d)",
                 write_address_0, write_data, cnt);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("wr_addr", 32'(write_address_0), 32'(e.a));
        chk("wr_data", write_data, e.d);
        chk("wr_cycle", 32'(cnt), 32'(e.c));
      end
    end
  end

  // One stimulus cycle: drive after the edge, check readies mid-cycle, queue expected writes.
  task automatic cyc(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                     input logic lv, input logic [4:0] la, input logic [31:0] ld,
                     input logic iv, input logic [4:0] ir,
                     input logic ear, input logic elr);
    exp_t e;
    @(posedge clk);
    #1;
    alu_wb_valid = av; alu_wb_addr = aa; alu_wb_data = ad;
    lsu_wb_valid = lv; lsu_wb_addr = la; lsu_wb_data = ld;
    issue_valid  = iv; issue_rd    = ir;
    @(negedge clk);
    chk("alu_ready", 32'(alu_wb_ready), 32'(ear));
    chk("lsu_ready", 32'(lsu_wb_ready), 32'(elr));
    if (ear && aa != 5'd0) begin
      e.a = aa; e.d = ad; e.c = cnt + 1; q.push_back(e);
    end
    if (elr && la != 5'd0) begin
      e.a = la; e.d = ld; e.c = cnt + 1; q.push_back(e);
    end
  endtask

  task automatic idle(input logic iv, input logic [4:0] ir);
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, iv, ir, 1'b0, 1'b0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Power-on reset
    repeat (2) @(negedge clk);
    chk("rst_write_en", 32'(write_en), 32'd0);
    chk("rst_addr", 32'(write_address_0), 32'd0);
    chk("rst_data", write_data, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_last_grant", 32'(last_grant), 32'd1);
    rst_n = 1'b1;

    // Lone ALU write to r1, plus issue rd=4
    cyc(1'b1, 5'd1, 32'hA5A5A5A5, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 1'b1, 1'b0);
    idle(1'b0, 5'd0);
    chk("last_grant_alu", 32'(last_grant), 32'd0);
    chk("busy4_set", 32'(busy[4]), 32'd1);

    // Mid-run reset with a handshake in flight: the write must be dropped
    cyc(1'b1, 5'd9, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    void'(q.pop_back());
    rst_n = 1'b0;
    alu_wb_valid = 1'b0;
    #1;
    chk("mid_rst_write_en", 32'(write_en), 32'd0);
    chk("mid_rst_busy", busy, 32'd0);
    chk("mid_rst_last_grant", 32'(last_grant), 32'd1);
    @(negedge clk);
    chk("mid_rst_hold_we", 32'(write_en), 32'd0);
    rst_n = 1'b1;

    // Both requesters valid for four cycles
`ifdef RF_WB_ARB_RR_EN
    cyc(1'b1, 5'd2, 32'h5A5A5A5A, 1'b1, 5'd3, 32'h12345678, 1'b0, 5'd0, 1'b1, 1'b0);
    cyc(1'b1, 5'd2, 32'h5A5A5A5A, 1'b1, 5'd3, 32'h12345678, 1'b0, 5'd0, 1'b0, 1'b1);
    cyc(1'b1, 5'd2, 32'h5A5A5A5A, 1'b1, 5'd3, 32'h12345678, 1'b0, 5'd0, 1'b1, 1'b0);
    cyc(1'b1, 5'd2, 32'h5A5A5A5A, 1'b1, 5'd3, 32'h12345678, 1'b0, 5'd0, 1'b0, 1'b1);
`else
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 5'd2, 32'h5A5A5A5A, 1'b1, 5'd3, 32'h12345678, 1'b0, 5'd0, 1'b0, 1'b1);
`endif
    idle(1'b0, 5'd0);
    chk("last_grant_lsu", 32'(last_grant), 32'd1);

    // Issue rd=5, LSU writes r5 three cycles later
    idle(1'b1, 5'd5);
    idle(1'b0, 5'd0);
    chk("busy5_n1", 32'(busy[5]), 32'd1);
    idle(1'b0, 5'd0);
    chk("busy5_n2", 32'(busy[5]), 32'd1);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h00000055, 1'b0, 5'd0, 1'b0, 1'b1);
    chk("busy5_n3", 32'(busy[5]), 32'd1);
    idle(1'b0, 5'd0);
    chk("busy5_wr_cycle", 32'(busy[5]), 32'd1);
    idle(1'b0, 5'd0);
    chk("busy5_cleared", 32'(busy[5]), 32'd0);

    // Issue rd=7 in the same cycle r7 is written: set wins
    idle(1'b1, 5'd7);
    cyc(1'b1, 5'd7, 32'h00000077, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    idle(1'b1, 5'd7);
    chk("we_during_r7_issue", 32'(write_en), 32'd1);
    idle(1'b0, 5'd0);
    chk("busy7_set_wins", 32'(busy[7]), 32'd1);

    // Write to r0 and issue to r0
    cyc(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b1, 1'b0);
    idle(1'b0, 5'd0);
    chk("r0_write_en", 32'(write_en), 32'd0);
    chk("busy0", 32'(busy[0]), 32'd0);

    // Back-to-back ALU writes
    cyc(1'b1, 5'd1, 32'h00000001, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    cyc(1'b1, 5'd2, 32'h00000002, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    cyc(1'b1, 5'd3, 32'h00000003, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    idle(1'b0, 5'd0);
    idle(1'b0, 5'd0);
    idle(1'b0, 5'd0);
    chk("pending_writes", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and scoreboard for the processor's 32 x 32-bit `RegisterFile`. It shares the register file's single write port between two write-back requesters, the ALU and the load/store unit (LSU), using a valid/ready handshake. It drives `write_en`/`write_address_0`/`write_data` from registers. It also keeps a 32-bit pending-write scoreboard, which the multi-cycle control FSM uses to stall operand reads.

## Interface
Parameters:
- `XLEN`, 32, data width
- `AW`, 5, register address width (2**AW registers)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `alu_wb_valid`  in  1  ALU write-back request
- `alu_wb_ready`  out  1  ALU request accepted this cycle
- `alu_wb_addr`  in  AW  ALU destination register
- `alu_wb_data`  in  XLEN  ALU result
- `lsu_wb_valid` / `lsu_wb_ready` / `lsu_wb_addr` / `lsu_wb_data`  in/out/in/in  1/1/AW/XLEN  same, for the LSU
- `issue_valid`  in  1  control FSM issued an instruction with a destination
- `issue_rd`  in  AW  destination of the issued instruction
- `busy`  out  2**AW  scoreboard; bit i = write to register i pending
- `write_en`  out  1  register-file write enable
- `write_address_0`  out  AW  register-file write address
- `write_data`  out  XLEN  register-file write data
- `last_grant`  out  1  0 = ALU, 1 = LSU; requester of the most recent accepted write

## Operation
- Handshake: a transfer occurs when `x_wb_valid && x_wb_ready`. Requesters hold valid, addr and data stable until ready. Ready is combinational from the valids and the arbiter state.
- At most one ready is asserted per cycle. A ready is never asserted without its valid.
- Only one requester valid: it is granted.
- Both valid: the winner comes from the arbitration policy (see Configuration).
- The grant pointer updates only on a completed transfer.
- Accepted transfer:
  - next cycle `write_en=1`, `write_address_0=addr`, `write_data=data`;
  - otherwise `write_en=0`;
  - address and data hold their last values.
- Address 0: the transfer is handshaken normally, but `write_en` stays 0 (r0 is hard zero).
- Scoreboard:
  - `issue_valid` with `issue_rd!=0` sets `busy[issue_rd]`;
  - the cycle `write_en=1`, `busy[write_address_0]` clears;
  - `busy[0]` is always 0.
- Simultaneous set and clear of the same bit: set wins (a newer instruction owns the register).
- Same address from both requesters on consecutive grants: the writes are applied in grant order. There is no merging.

## Timing
- Reset (async assert, sync release): `write_en=0`, `write_address_0=0`, `write_data=0`, `busy=0`, `last_grant=1` (ALU favoured first).
- Reset in mid-handshake drops any in-flight write. No output glitch occurs beyond the async clear.
- Latency: handshake in cycle N, register-file write in cycle N+1 (combinational `RegisterFile` sees it the same cycle). `busy` clears at the N+1 edge, so it is visible low in N+2.
- Throughput: one write per cycle sustained. There are no bubbles between back-to-back grants.
- `busy` is a registered output. An `issue_valid` in cycle N is visible in N+1.

## Configuration
Macro `RF_WB_ARB_RR_EN`:
- Defined: round-robin. When both requesters are valid, the requester not equal to `last_grant` wins. Starvation-free; each requester waits at most 1 grant.
- Undefined: fixed priority, LSU over ALU. `last_grant` is still reported. The ALU may starve while the LSU holds valid.

## Structure
- Shared package `regfile_pkg`:
  - `XLEN`, `AW`, `NUM_REGS`;
  - `typedef enum logic {REQ_ALU=0, REQ_LSU=1} wb_req_e`;
  - `REG_ZERO=0`.
- One sub-module, `rr_arbiter2`: 2-way grant logic plus pointer, holding the macro-dependent policy.
- Write-port registers and the scoreboard live in the top module.

## Test plan
- Reset with `rst_n=0` mid-run → next sample shows `write_en=0`, `busy=0`, `last_grant=1`. After release, a lone ALU request to r1 with `A5A5A5A5` → `alu_wb_ready=1`, next cycle `write_en=1`, addr 1, data `A5A5A5A5`.
- Both valid for 4 cycles (ALU→r2 `5A5A5A5A`, LSU→r3 `12345678`), requesters re-present after each grant → with `RF_WB_ARB_RR_EN`, grants alternate ALU, LSU, ALU, LSU; without it, LSU every cycle and `alu_wb_ready=0`.
- `issue_valid` rd=5, then an LSU write to r5 three cycles later → `busy[5]` high from issue+1 until the edge after `write_en`.
- `issue_valid` rd=7 in the same cycle as `write_en=1` to r7 → `busy[7]` remains 1.
- ALU write to r0 with data `FFFFFFFF` → `alu_wb_ready=1`, `write_en` stays 0. `issue_rd=0` → `busy[0]` stays 0.
- Back-to-back ALU writes r1, r2, r3 on consecutive cycles → `write_en` high for 3 consecutive cycles with addresses 1, 2, 3.
